// File: rtl/ram_sp_be_param.sv
// Parametrised single-port RAM with per-column write enables, 1- or 2-cycle
// read latency, a read-valid strobe and a zero-fill clear engine that runs
// after reset (optional) or on request.
module ram_sp_be_param #(
   parameter int ADR_WD     = 8,
   parameter int DEPTH      = 192,
   parameter int DAT_WD     = 128,
   parameter int COL_WD     = 1,
   parameter int RD_LAT     = 1,
   parameter int CLR_ON_RST = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [ADR_WD-1:0]        adr_i,
   input  logic [DAT_WD/COL_WD-1:0] wr_ena_i,
   input  logic [DAT_WD-1:0]        wr_dat_i,
   input  logic                     rd_ena_i,
   input  logic                     clr_req_i,
   output logic [DAT_WD-1:0]        rd_dat_o,
   output logic                     rd_val_o,
   output logic                     busy_o
);

   localparam int                NCOL     = DAT_WD / COL_WD;
   localparam logic [ADR_WD:0]   LP_DEPTH = (ADR_WD+1)'(DEPTH);
   localparam logic [ADR_WD-1:0] LP_LAST  = ADR_WD'(DEPTH - 1);

   typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

   state_t              r_state;
   logic [ADR_WD-1:0]   r_cnt;
   logic [DAT_WD-1:0]   r_mem [DEPTH];
   logic [DAT_WD-1:0]   r_rd_dat;
   logic                r_rd_val;

   logic                w_busy;
   logic                w_in_rng;
   logic                w_rd_go;
   logic [DAT_WD-1:0]   w_rd_word;

   // While clearing, the user port is locked out entirely.
   assign w_busy    = (r_state == ST_CLEAR);
   assign w_in_rng  = ({1'b0, adr_i} < LP_DEPTH);
   assign w_rd_go   = !w_busy && rd_ena_i;
   // Out-of-range reads still complete, returning zero.
   assign w_rd_word = w_in_rng ? r_mem[adr_i] : '0;

   assign busy_o   = w_busy;
   assign rd_dat_o = r_rd_dat;
   assign rd_val_o = r_rd_val;

   // Clear engine: walks r_cnt over every word, then returns to IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (clr_req_i) begin
                  r_state <= ST_CLEAR;
                  r_cnt   <= '0;
               end
            end
            ST_CLEAR: begin
               if (r_cnt == LP_LAST) begin
                  r_state <= ST_IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + ADR_WD'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   // Array update: zero-fill while clearing, otherwise masked column writes.
   // NOTE: the storage array has no reset branch; clearing is done one word
   // per cycle by the engine so the array maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (w_busy) begin
            r_mem[r_cnt] <= '0;
         end else if (w_in_rng) begin
            for (int k = 0; k < NCOL; k++) begin
               if (wr_ena_i[k]) begin
                  r_mem[adr_i][k*COL_WD +: COL_WD] <= wr_dat_i[k*COL_WD +: COL_WD];
               end
            end
         end
      end
   end

   generate
      if (RD_LAT == 1) begin : g_lat1
         // Single-stage read: the sampled word lands on the output directly.
         always_ff @(posedge clk) begin
            if (rst) begin
               r_rd_dat <= '0;
               r_rd_val <= 1'b0;
            end else begin
               r_rd_val <= w_rd_go;
               if (w_rd_go) begin
                  r_rd_dat <= w_rd_word;
               end
            end
         end
      end else begin : g_lat2
         logic [DAT_WD-1:0] r_stg_dat;
         logic              r_stg_val;

         // Two-stage read: array sample, then output register; fully pipelined.
         always_ff @(posedge clk) begin
            if (rst) begin
               r_stg_dat <= '0;
               r_stg_val <= 1'b0;
               r_rd_dat  <= '0;
               r_rd_val  <= 1'b0;
            end else begin
               r_stg_val <= w_rd_go;
               if (w_rd_go) begin
                  r_stg_dat <= w_rd_word;
               end
               r_rd_val <= r_stg_val;
               if (r_stg_val) begin
                  r_rd_dat <= r_stg_dat;
               end
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_ram_sp_be_param.sv
// Bench for ram_sp_be_param: one instance with read latency 1 and one with
// latency 2 share all inputs; both are compared every cycle against a
// word-array reference model.
module tb_ram_sp_be_param;

   localparam int ADR_WD = 8;
   localparam int DEPTH  = 192;
   localparam int DAT_WD = 128;
   localparam int COL_WD = 1;
   localparam int NCOL   = DAT_WD / COL_WD;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [ADR_WD-1:0] adr = '0;
   logic [NCOL-1:0]   wr_ena = '0;
   logic [DAT_WD-1:0] wr_dat = '0;
   logic              rd_ena = 1'b0;
   logic              clr_req = 1'b0;

   logic [DAT_WD-1:0] rd_dat1, rd_dat2;
   logic              rd_val1, rd_val2, busy1, busy2;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   logic [DAT_WD-1:0] m_mem [DEPTH];
   int                clr_left = 0;
   logic              m_v1 = 1'b0, m_v2 = 1'b0, m_sv = 1'b0;
   logic [DAT_WD-1:0] m_d1 = '0, m_d2 = '0, m_sd = '0;

   ram_sp_be_param #(.ADR_WD(ADR_WD), .DEPTH(DEPTH), .DAT_WD(DAT_WD), .COL_WD(COL_WD),
                     .RD_LAT(1), .CLR_ON_RST(1)) u_dut1 (
      .clk(clk), .rst(rst), .adr_i(adr), .wr_ena_i(wr_ena), .wr_dat_i(wr_dat),
      .rd_ena_i(rd_ena), .clr_req_i(clr_req),
      .rd_dat_o(rd_dat1), .rd_val_o(rd_val1), .busy_o(busy1));

   ram_sp_be_param #(.ADR_WD(ADR_WD), .DEPTH(DEPTH), .DAT_WD(DAT_WD), .COL_WD(COL_WD),
                     .RD_LAT(2), .CLR_ON_RST(1)) u_dut2 (
      .clk(clk), .rst(rst), .adr_i(adr), .wr_ena_i(wr_ena), .wr_dat_i(wr_dat),
      .rd_ena_i(rd_ena), .clr_req_i(clr_req),
      .rd_dat_o(rd_dat2), .rd_val_o(rd_val2), .busy_o(busy2));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DAT_WD-1:0] got,
                        input logic [DAT_WD-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   // Apply the architectural rules for one clock edge.
   task automatic model_edge();
      logic              issued;
      logic [DAT_WD-1:0] res;
      int                a;
      issued = 1'b0;
      res    = '0;
      a      = int'(adr);
      if (rst) begin
         clr_left = DEPTH;
         m_v1 = 1'b0; m_d1 = '0;
         m_sv = 1'b0; m_sd = '0;
         m_v2 = 1'b0; m_d2 = '0;
      end else begin
         m_v2 = m_sv;
         if (m_sv) m_d2 = m_sd;
         if (clr_left > 0) begin
            m_mem[DEPTH - clr_left] = '0;
            clr_left--;
         end else begin
            if (rd_ena) begin
               issued = 1'b1;
               res    = (a < DEPTH) ? m_mem[a] : '0;
            end
            if (a < DEPTH) begin
               for (int k = 0; k < NCOL; k++)
                  if (wr_ena[k]) m_mem[a][k*COL_WD +: COL_WD] = wr_dat[k*COL_WD +: COL_WD];
            end
            if (clr_req) clr_left = DEPTH;
         end
         m_v1 = issued;
         if (issued) m_d1 = res;
         m_sv = issued;
         if (issued) m_sd = res;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("busy_l1", busy1, clr_left > 0);
      check("busy_l2", busy2, clr_left > 0);
      check("val_l1", rd_val1, m_v1);
      check("dat_l1", rd_dat1, m_d1);
      check("val_l2", rd_val2, m_v2);
      check("dat_l2", rd_dat2, m_d2);
   endtask

   task automatic idle_in();
      rst = 1'b0; wr_ena = '0; rd_ena = 1'b0; clr_req = 1'b0;
   endtask

   task automatic rand_in();
      adr    = ADR_WD'($urandom_range(0, 255));
      rd_ena = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
         0:       wr_ena = '0;
         1:       wr_ena = '1;
         default: wr_ena = {$urandom, $urandom, $urandom, $urandom};
      endcase
      wr_dat  = {$urandom, $urandom, $urandom, $urandom};
      clr_req = ($urandom_range(0, 299) == 0);
   endtask

   // Count busy cycles (bounded); optionally throw traffic at the locked port.
   task automatic wait_clear(input bit junk, output int n);
      n = 0;
      while (busy1 === 1'b1 && n < 1000) begin
         if (junk) rand_in();
         n++;
         step();
      end
      idle_in();
   endtask

   task automatic rd(input int a);
      adr = ADR_WD'(a); rd_ena = 1'b1; wr_ena = '0;
      step();
      rd_ena = 1'b0;
   endtask

   int n_busy;

   initial begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

      // Reset and initial zero-fill
      rst = 1'b1;
      step();
      idle_in();
      wait_clear(1'b0, n_busy);
      check("busy_len_reset", DAT_WD'(n_busy), DAT_WD'(DEPTH));
      rd(0); rd(95); rd(191);
      step(); step();

      // Column-masked write
      adr = 5; wr_ena = '1; wr_dat = '1; step();
      wr_ena = {{64{1'b0}}, {64{1'b1}}}; wr_dat = '0; step();
      idle_in();
      rd(5); step(); step();

      // Read-before-write in the same cycle
      adr = 7; wr_ena = '1; wr_dat = {16{8'h3C}}; step();
      adr = 7; wr_ena = '1; wr_dat = {16{8'hA5}}; rd_ena = 1'b1; step();
      idle_in();
      rd(7); step(); step();

      // Back-to-back reads
      rd(1); rd(2); rd(3); rd(5); step(); step(); step();

      // Out-of-range access
      adr = 200; wr_ena = '1; wr_dat = '1; step();
      idle_in();
      rd(200); rd(255);
      for (int i = 0; i < DEPTH; i++) rd(i);
      step(); step();

      // Clear request amid traffic, then reset part-way through the clear
      for (int i = 0; i < 20; i++) begin rand_in(); clr_req = 1'b0; step(); end
      rand_in(); clr_req = 1'b1; step();
      for (int i = 0; i < 99; i++) begin rand_in(); step(); end
      idle_in();
      rst = 1'b1; step();
      rst = 1'b0;
      wait_clear(1'b1, n_busy);
      check("busy_len_restart", DAT_WD'(n_busy), DAT_WD'(DEPTH));
      for (int i = 0; i < DEPTH; i += 17) rd(i);
      step(); step();

      // Randomised traffic with occasional clears and resets
      for (int i = 0; i < 3000; i++) begin
         rand_in();
         rst = ($urandom_range(0, 999) == 0);
         step();
      end
      idle_in();
      wait_clear(1'b0, n_busy);
      for (int i = 0; i < DEPTH; i++) rd(i);
      step(); step(); step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
